// File: rtl/dl_bus_arbiter.sv
// Load-port arbiter for the core: muxes the HPS download stream and the high-score
// engine onto dn_addr/dn_data/dn_wr, and sequences core_reset around downloads.
`timescale 1ns/1ps

module dl_bus_arbiter #(
  parameter int unsigned ROM_SIZE    = 65536,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        hs_req,
  input  logic [15:0] hs_addr,
  input  logic [7:0]  hs_data,
  output logic        hs_ack,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic        core_reset,
  output logic        dl_busy,
  output logic        dl_overflow,
  output logic [16:0] dl_bytes
);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DL   = 2'd2
  } state_e;

  localparam logic [24:0] ROM_LIMIT   = 25'(ROM_SIZE);
  localparam logic [16:0] BYTES_MAX   = 17'(ROM_SIZE);
  localparam logic [7:0]  HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic        core_reset_q, core_reset_d;
  logic        dl_busy_q, dl_busy_d;
  logic        dl_overflow_q, dl_overflow_d;
  logic [16:0] dl_bytes_q, dl_bytes_d;
  logic        dn_wr_q, dn_wr_d;
  logic [15:0] dn_addr_q, dn_addr_d;
  logic [7:0]  dn_data_q, dn_data_d;
  logic        hs_ack_q, hs_ack_d;

  logic enter_dl, dl_accept, dl_drop, hs_grant;

  // NOTE: reset is sampled on the clock edge only, so it lives inside the
  // clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q       <= ST_HOLD;
      hold_cnt_q    <= HOLD_RELOAD;
      core_reset_q  <= 1'b1;
      dl_busy_q     <= 1'b0;
      dl_overflow_q <= 1'b0;
      dl_bytes_q    <= '0;
      dn_wr_q       <= 1'b0;
      dn_addr_q     <= '0;
      dn_data_q     <= '0;
      hs_ack_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop reading pre-edge values.
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      core_reset_q  <= core_reset_d;
      dl_busy_q     <= dl_busy_d;
      dl_overflow_q <= dl_overflow_d;
      dl_bytes_q    <= dl_bytes_d;
      dn_wr_q       <= dn_wr_d;
      dn_addr_q     <= dn_addr_d;
      dn_data_q     <= dn_data_d;
      hs_ack_q      <= hs_ack_d;
    end
  end

  // Next-state: a download request always wins, including over an expiring hold.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch behind.
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      ST_HOLD: begin
        if (ioctl_download)        state_d = ST_DL;
        else if (hold_cnt_q == '0) state_d = ST_RUN;
        else                       hold_cnt_d = hold_cnt_q - 8'd1;
      end
      ST_RUN: begin
        if (ioctl_download) state_d = ST_DL;
      end
      ST_DL: begin
        if (!ioctl_download) begin
          state_d    = ST_HOLD;
          hold_cnt_d = HOLD_RELOAD;
        end
      end
      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = HOLD_RELOAD;
      end
    endcase
  end

  // Outputs: everything is registered, so these are the _d values of the output flops.
  always_comb begin
    enter_dl  = (state_d == ST_DL) && (state_q != ST_DL);
    dl_accept = (state_q == ST_DL) && ioctl_wr && (ioctl_addr < ROM_LIMIT);
    dl_drop   = (state_q == ST_DL) && ioctl_wr && !(ioctl_addr < ROM_LIMIT);
    hs_grant  = (state_q == ST_RUN) && !ioctl_download && hs_req && !hs_ack_q;

    dn_wr_d       = 1'b0;
    dn_addr_d     = dn_addr_q;
    dn_data_d     = dn_data_q;
    hs_ack_d      = 1'b0;
    dl_bytes_d    = dl_bytes_q;
    dl_overflow_d = dl_overflow_q;

    if (dl_accept) begin
      dn_wr_d   = 1'b1;
      dn_addr_d = ioctl_addr[15:0];
      dn_data_d = ioctl_dout;
      if (dl_bytes_q != BYTES_MAX) dl_bytes_d = dl_bytes_q + 17'd1;
    end else if (hs_grant) begin
      dn_wr_d   = 1'b1;
      dn_addr_d = hs_addr;
      dn_data_d = hs_data;
      hs_ack_d  = 1'b1;
    end

    if (dl_drop) dl_overflow_d = 1'b1;

    // A fresh download starts its statistics from zero on the entering edge.
    if (enter_dl) begin
      dl_bytes_d    = '0;
      dl_overflow_d = 1'b0;
    end

    core_reset_d = (state_d != ST_RUN);
    dl_busy_d    = (state_d == ST_DL);
  end

  assign hs_ack      = hs_ack_q;
  assign dn_addr     = dn_addr_q;
  assign dn_data     = dn_data_q;
  assign dn_wr       = dn_wr_q;
  assign core_reset  = core_reset_q;
  assign dl_busy     = dl_busy_q;
  assign dl_overflow = dl_overflow_q;
  assign dl_bytes    = dl_bytes_q;

endmodule

// File: doc/dl_bus_arbiter.md
Name: dl_bus_arbiter

Overview:
- Owns the core's single ROM/RAM load port (dn_addr/dn_data/dn_wr) and arbitrates it between two requesters: the HPS ioctl download stream and a high-score save/restore engine.
- Sequences the core reset: the core is held in reset during a download and for a fixed settle period afterwards.
- Provides download status for the LED and the OSD.
- Sits between hps_io and the ladybug core instance in the emu top.

Parameters:
- ROM_SIZE, 65536: number of valid download bytes (1..65536). Any byte whose address is ROM_SIZE or higher is dropped.
- HOLD_CYCLES, 16: number of clk_sys cycles core_reset stays high after power-up or after a download ends (range 1..255).

Ports:
- clk_sys  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- ioctl_download  in  1  download in progress (level).
- ioctl_wr  in  1  download byte strobe; one-cycle pulse, minimum spacing 2 cycles.
- ioctl_addr  in  25  download byte address.
- ioctl_dout  in  8  download byte data.
- hs_req  in  1  high-score write request (level).
- hs_addr  in  16  high-score write address.
- hs_data  in  8  high-score write data.
- hs_ack  out  1  one-cycle grant pulse for hs_req.
- dn_addr  out  16  load-port address to the core.
- dn_data  out  8  load-port data to the core.
- dn_wr  out  1  load-port write strobe.
- core_reset  out  1  reset to the core, active high.
- dl_busy  out  1  high in the DL state.
- dl_overflow  out  1  sticky: an out-of-range download byte was dropped.
- dl_bytes  out  17  count of accepted download bytes.

Behaviour:
- Reset values (reset_n=0):
  - state is HOLD and hold_cnt is HOLD_CYCLES-1.
  - core_reset=1; dn_wr=0, dn_addr=0, dn_data=0, hs_ack=0.
  - dl_busy=0, dl_overflow=0, dl_bytes=0.
- State machine, evaluated each cycle:
  - HOLD, ioctl_download=1: go to DL.
  - HOLD, hold_cnt=0: go to RUN.
  - HOLD, otherwise: decrement hold_cnt.
  - RUN, ioctl_download=1: go to DL.
  - DL, ioctl_download=0: go to HOLD and reload hold_cnt=HOLD_CYCLES-1.
- Entering DL from any state:
  - clears dl_bytes and dl_overflow in the same edge.
  - aborts any HOLD countdown.
- core_reset is a registered output:
  - 1 in HOLD and DL, 0 in RUN.
  - Deasserts on the edge that enters RUN; total HOLD duration is exactly HOLD_CYCLES cycles.
- dl_busy is registered and equals (state==DL).
- Download path, active only in DL:
  - Condition: ioctl_wr=1 and ioctl_addr < ROM_SIZE, compared as a full 25-bit unsigned value.
  - Next cycle: dn_wr=1, dn_addr=ioctl_addr[15:0], dn_data=ioctl_dout, and dl_bytes increments.
  - Latency from ioctl_wr to dn_wr is exactly 1 cycle.
  - If ioctl_wr=1 and ioctl_addr >= ROM_SIZE: no dn_wr, dl_bytes unchanged, dl_overflow set to 1.
  - ioctl_wr outside DL (including in the cycle DL is entered, when state is not yet DL) is ignored.
  - dl_bytes cannot exceed ROM_SIZE and never wraps.
- High-score path, active only in RUN:
  - Condition: ioctl_download=0, hs_req=1, hs_ack=0.
  - Next cycle: dn_wr=1, dn_addr=hs_addr, dn_data=hs_data, hs_ack=1.
  - hs_ack is asserted in the same cycle as the corresponding dn_wr.
  - hs_req is ignored in any cycle where hs_ack=1, so grants are spaced at least 2 cycles apart.
  - The requester drops hs_req or presents the next word after seeing hs_ack.
- Priority:
  - The download always wins.
  - If ioctl_download rises in the same cycle as a pending hs_req, no hs grant is issued; hs_req stays pending, unacknowledged, until RUN is re-entered.
  - A grant issued in the previous cycle always completes (dn_wr and hs_ack pulse once) even if the state moved to DL.
  - hs_req during HOLD or DL is never acknowledged.
- dn_wr is a single-cycle pulse per accepted byte. dn_addr and dn_data hold their last values when dn_wr=0.
- Reset mid-download (reset_n=0 while ioctl_download=1):
  - All outputs take their reset values; state is HOLD.
  - The first cycle after reset_n rises, the arbiter re-enters DL and clears the counters again.

Test Plan:
- Power-up: release reset_n with HOLD_CYCLES=16 and no other activity → core_reset falls exactly 16 cycles after reset_n rises; dn_wr stays 0 throughout.
- Download: ioctl_download=1, then 4 writes at addresses 0..3 with data A5,5A,FF,00, spaced 2 cycles, then ioctl_download=0.
  - Each dn_wr appears 1 cycle after its ioctl_wr with matching address and data.
  - dl_bytes=4, dl_busy is high during the download, core_reset is high throughout.
  - core_reset falls 16 cycles after ioctl_download falls.
- Overflow: ROM_SIZE=16'h4000; write at 0x3FFF, then 0x4000, then 0x1_0000 → exactly one dn_wr (address 0x3FFF), dl_bytes=1, dl_overflow=1. A new download start clears dl_overflow.
- High score in RUN: hold hs_req=1 with address 0x6000, data 0x12 for 6 cycles → hs_ack and dn_wr pulse together on cycles 1, 3 and 5 (three writes), each carrying 0x6000/0x12.
- Collision: hs_req=1 and ioctl_download rising in the same cycle → no hs_ack; DL is entered. After the download plus 16 hold cycles, the first RUN cycle issues the grant.
- Reset mid-download: pulse reset_n low for 1 cycle during a download with dl_bytes=7 → dl_bytes=0 and core_reset=1; DL is re-entered and subsequent writes count from 1.
